// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB definitions for the bus-matrix slave-port arbiter: transfer and
// burst encodings, arbiter state, and the fixed-burst length helper.
package AHB_package;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [0:0] {
    ARB_FREE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Beats in a fixed-length burst; INCR is unbounded and reported as 0.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE:                burst_len = 5'd1;
      HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
      default:                      burst_len = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_arbiter_prio_rr_pick.sv
// Combinational pick: highest priority wins, round-robin among equals,
// searching circularly from the index after rr_ptr.
// Ports: req (request vector), prio (packed per-requester priority),
//        rr_ptr (last winner), grant_oh/grant_idx (winner), any (some request).
module ahb_prio_rr_pick #(
  parameter  int unsigned N_REQ  = 4,
  parameter  int unsigned PRIO_W = 2,
  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*PRIO_W-1:0] prio,
  input  logic [IDX_W-1:0]        rr_ptr,
  output logic [N_REQ-1:0]        grant_oh,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    any
);

  logic [PRIO_W-1:0] max_prio;
  logic [N_REQ-1:0]  top_req;

  // Requesters sharing the highest priority among those requesting.
  always_comb begin
    max_prio = '0;
    top_req  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req[i] && (prio[i*PRIO_W +: PRIO_W] > max_prio)) begin
        max_prio = prio[i*PRIO_W +: PRIO_W];
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      top_req[i] = req[i] && (prio[i*PRIO_W +: PRIO_W] == max_prio);
    end
  end

  // First top requester strictly after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = (int'(rr_ptr) + k) % int'(N_REQ);
      if (!any && top_req[idx]) begin
        any           = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave-port AHB arbiter. Grants the slave to one master for a whole
// burst, counting beats of fixed-length bursts and honouring early
// termination, with priority + round-robin selection on each handover.
// Ports: hclk/hreset (sync, active-high), hreq/hprior (per-master request and
//        priority), htrans/hburst/hwait (from the granted master and slave),
//        hgrant (registered one-hot mux select), hsel (slave select),
//        hmaster (owner index), burst_active (fixed burst beats outstanding).
module ahb_slave_arbiter
  import AHB_package::*;
#(
  parameter  int unsigned N_REQ  = 4,
  parameter  int unsigned PRIO_W = 2,
  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic [N_REQ-1:0]        hreq,
  input  logic [N_REQ*PRIO_W-1:0] hprior,
  input  logic [1:0]              htrans,
  input  logic [2:0]              hburst,
  input  logic                    hwait,
  output logic [N_REQ-1:0]        hgrant,
  output logic                    hsel,
  output logic [IDX_W-1:0]        hmaster,
  output logic                    burst_active
);

  arb_state_e       state_q,  state_d;
  logic [N_REQ-1:0] grant_q,  grant_d;
  logic [IDX_W-1:0] master_q, master_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [4:0]       rem_q,    rem_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             beat_c;
  logic             rel_c;
  logic             take_c;
  logic [4:0]       blen;
  logic             is_incr;

  ahb_prio_rr_pick #(
    .N_REQ (N_REQ),
    .PRIO_W(PRIO_W)
  ) u_pick (
    .req      (hreq),
    .prio     (hprior),
    .rr_ptr   (rr_ptr_q),
    .grant_oh (pick_oh),
    .grant_idx(pick_idx),
    .any      (pick_any)
  );

  assign hgrant       = grant_q;
  assign hmaster      = master_q;
  assign hsel         = |(grant_q & hreq);
  assign burst_active = (state_q == ARB_OWNED) && (rem_q != 5'd0);

  assign beat_c  = hsel & htrans[1] & ~hwait;
  assign blen    = burst_len(hburst);
  assign is_incr = (hburst == HBURST_INCR);

  // Next state: grant on request, beat counting, release and same-cycle handover.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    master_d = master_q;
    rr_ptr_d = rr_ptr_q;
    rem_d    = rem_q;
    rel_c    = 1'b0;
    take_c   = 1'b0;

    if (!hwait) begin
      if (state_q == ARB_FREE) begin
        take_c = pick_any;
      end else begin
        if (!hsel) begin
          // Owner dropped its request: INCR end, early termination or idle hold.
          rel_c = 1'b1;
        end else if (beat_c) begin
          if (htrans == HTRANS_NONSEQ) begin
            if (!is_incr && (blen == 5'd1)) rel_c = 1'b1;
            else                            rem_d = is_incr ? 5'd0 : blen - 5'd1;
          end else if (!is_incr) begin
            // rem of 0 here cannot underflow; treat it as the last beat.
            if (rem_q <= 5'd1) rel_c = 1'b1;
            else               rem_d = rem_q - 5'd1;
          end
        end

        if (rel_c) begin
          rem_d = 5'd0;
          if (pick_any) begin
            take_c = 1'b1;
          end else begin
            state_d = ARB_FREE;
            grant_d = '0;
          end
        end
      end
    end

    if (take_c) begin
      state_d  = ARB_OWNED;
      grant_d  = pick_oh;
      master_d = pick_idx;
      rr_ptr_d = pick_idx;
    end
  end

  // State registers; rr_ptr resets to the last index so index 0 wins first.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= ARB_FREE;
      grant_q  <= '0;
      master_q <= '0;
      rr_ptr_q <= IDX_W'(N_REQ - 1);
      rem_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      rr_ptr_q <= rr_ptr_d;
      rem_q    <= rem_d;
    end
  end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Self-checking bench for ahb_slave_arbiter (4 masters, 2-bit priority):
// directed scenarios followed by randomized traffic against a reference model.
module tb_ahb_slave_arbiter;

  logic       hclk;
  logic       hreset;
  logic [3:0] hreq;
  logic [7:0] hprior;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hwait;
  logic [3:0] hgrant;
  logic       hsel;
  logic [1:0] hmaster;
  logic       burst_active;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 when free), last winner, and the
  // length / accepted-beat count of the current fixed burst.
  int m_owner  = -1;
  int m_master = 0;
  int m_rr     = 3;
  int m_len    = 0;
  int m_done   = 0;

  ahb_slave_arbiter #(.N_REQ(4), .PRIO_W(2)) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .hreq        (hreq),
    .hprior      (hprior),
    .htrans      (htrans),
    .hburst      (hburst),
    .hwait       (hwait),
    .hgrant      (hgrant),
    .hsel        (hsel),
    .hmaster     (hmaster),
    .burst_active(burst_active)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int len_of(input logic [2:0] b);
    case (b)
      3'd0:       return 1;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 0;
    endcase
  endfunction

  // Scan from the slot after rr; a strictly greater priority replaces the
  // candidate, so the first of the highest-priority requesters is kept.
  function automatic int m_pick(input logic [3:0] r, input logic [7:0] p, input int rr);
    int best;
    int bp;
    int i;
    best = -1;
    bp   = -1;
    for (int k = 1; k <= 4; k++) begin
      i = (rr + k) % 4;
      if (r[i] && (int'(p[i*2 +: 2]) > bp)) begin
        bp   = int'(p[i*2 +: 2]);
        best = i;
      end
    end
    return best;
  endfunction

  task automatic m_take(input int p);
    m_owner  = p;
    m_master = p;
    m_rr     = p;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int  p;
    bit  rel;
    p   = m_pick(hreq, hprior, m_rr);
    rel = 1'b0;
    if (hreset) begin
      m_owner  = -1;
      m_master = 0;
      m_rr     = 3;
      m_len    = 0;
      m_done   = 0;
    end else if (!hwait) begin
      if (m_owner < 0) begin
        if (p >= 0) m_take(p);
      end else begin
        if (!hreq[m_owner]) begin
          rel = 1'b1;
        end else if (htrans == 2'd2) begin
          if (hburst == 3'd0) rel = 1'b1;
          else begin
            m_len  = len_of(hburst);
            m_done = 1;
          end
        end else if ((htrans == 2'd3) && (hburst != 3'd1)) begin
          m_done++;
          if (m_done >= m_len) rel = 1'b1;
        end
        if (rel) begin
          m_len  = 0;
          m_done = 0;
          if (p >= 0) m_take(p);
          else        m_owner = -1;
        end
      end
    end
  endtask

  // One clock: update the model, clock the DUT, compare every output.
  task automatic cycle();
    logic [3:0] eg;
    model_step();
    @(posedge hclk);
    #1;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    chk("hgrant", 32'(hgrant), 32'(eg));
    chk("hmaster", 32'(hmaster), 32'(m_master));
    chk("burst_active", 32'(burst_active), 32'((m_owner >= 0) && (m_len - m_done > 0)));
    chk("hsel", 32'(hsel), 32'((m_owner >= 0) && hreq[m_owner]));
  endtask

  task automatic do_reset(input logic [3:0] req, input logic [7:0] prio);
    hreset = 1'b1;
    hreq   = req;
    hprior = prio;
    htrans = 2'd0;
    hburst = 3'd0;
    hwait  = 1'b0;
    cycle();
    hreset = 1'b0;
  endtask

  initial begin
    hreset = 1'b1;
    hreq   = 4'b0000;
    hprior = 8'h00;
    htrans = 2'd0;
    hburst = 3'd0;
    hwait  = 1'b0;

    // Reset state and SINGLE rotation with equal priorities.
    do_reset(4'b1111, 8'h00);
    chk("rst_hgrant", 32'(hgrant), 32'h0);
    chk("rst_hmaster", 32'(hmaster), 32'h0);
    chk("rst_burst_active", 32'(burst_active), 32'h0);
    chk("rst_hsel", 32'(hsel), 32'h0);
    cycle();
    chk("rot_first", 32'(hgrant), 32'h1);
    htrans = 2'd2;
    hburst = 3'd0;
    cycle(); chk("rot_1", 32'(hgrant), 32'h2);
    cycle(); chk("rot_2", 32'(hgrant), 32'h4);
    cycle(); chk("rot_3", 32'(hgrant), 32'h8);
    cycle(); chk("rot_wrap", 32'(hgrant), 32'h1);

    // Priority: idx2 has prio 3 and beats idx0 (prio 1).
    do_reset(4'b0101, {2'd0, 2'd3, 2'd0, 2'd1});
    cycle();
    chk("prio_grant", 32'(hgrant), 32'h4);
    chk("prio_hmaster", 32'(hmaster), 32'd2);

    // INCR8 by master 1 with wait states; master 0 waits at higher priority.
    do_reset(4'b0010, {2'd0, 2'd0, 2'd0, 2'd1});
    cycle();
    chk("incr8_grant", 32'(hgrant), 32'h2);
    hburst = 3'd5;
    for (int b = 1; b <= 8; b++) begin
      htrans = (b == 1) ? 2'd2 : 2'd3;
      if (b >= 2) hreq = 4'b0011;
      if (b == 3 || b == 6) begin
        hwait = 1'b1;
        cycle();
        chk("incr8_wait_hold", 32'(hgrant), 32'h2);
        hwait = 1'b0;
      end
      cycle();
      if (b < 8) begin
        chk("incr8_hold", 32'(hgrant), 32'h2);
        chk("incr8_active", 32'(burst_active), 32'h1);
      end else begin
        chk("incr8_handover", 32'(hgrant), 32'h1);
        chk("incr8_active_fall", 32'(burst_active), 32'h0);
      end
    end
    htrans = 2'd0;

    // Early termination of WRAP4 after two beats.
    do_reset(4'b0001, 8'h00);
    cycle();
    hburst = 3'd2;
    htrans = 2'd2;
    cycle();
    chk("wrap4_active", 32'(burst_active), 32'h1);
    htrans = 2'd3;
    cycle();
    hreq = 4'b0000;
    cycle();
    chk("early_grant", 32'(hgrant), 32'h0);
    chk("early_active", 32'(burst_active), 32'h0);
    cycle();
    chk("early_no_hsel", 32'(hsel), 32'h0);

    // Undefined-length INCR with BUSY cycles; master 2 waits at equal priority.
    do_reset(4'b0101, 8'h00);
    cycle();
    chk("incr_grant", 32'(hgrant), 32'h1);
    hburst = 3'd1;
    for (int b = 1; b <= 20; b++) begin
      htrans = (b == 1) ? 2'd2 : 2'd3;
      cycle();
      chk("incr_hold", 32'(hgrant), 32'h1);
      if (b % 3 == 0) begin
        htrans = 2'd1;
        cycle();
        chk("incr_busy_hold", 32'(hgrant), 32'h1);
      end
    end
    hreq   = 4'b0100;
    htrans = 2'd0;
    cycle();
    chk("incr_release", 32'(hgrant), 32'h4);

    // Synchronous reset during beat 5 of INCR16.
    do_reset(4'b0010, 8'h00);
    cycle();
    hburst = 3'd7;
    for (int b = 1; b <= 4; b++) begin
      htrans = (b == 1) ? 2'd2 : 2'd3;
      cycle();
    end
    chk("incr16_active", 32'(burst_active), 32'h1);
    chk("incr16_hmaster", 32'(hmaster), 32'd1);
    hreset = 1'b1;
    cycle();
    chk("midrst_hgrant", 32'(hgrant), 32'h0);
    chk("midrst_hmaster", 32'(hmaster), 32'h0);
    chk("midrst_active", 32'(burst_active), 32'h0);
    chk("midrst_hsel", 32'(hsel), 32'h0);
    hreset = 1'b0;
    hreq   = 4'b1111;
    htrans = 2'd0;
    cycle();
    chk("midrst_rr", 32'(hgrant), 32'h1);

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 1500; n++) begin
      hreset = ($urandom_range(0, 99) == 0);
      hreq   = 4'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 7) != 0) hreq[m_owner] = 1'b1;
      hprior = 8'($urandom);
      htrans = 2'($urandom);
      if (htrans == 2'd2) hburst = 3'($urandom);
      hwait  = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
